// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, single-cycle instruction-memory port and a
// 2-entry {pc, instr} buffer toward decode. Define IFETCH_PERF_CNT_EN to add stall_cnt.
module instr_fetch #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-3:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] START_PC  = RESET_PC & WORD_MASK;
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [ADDR_W-1:0] target_pc;

    logic [ADDR_W-1:0] fifo_pc    [2];
    logic [31:0]       fifo_instr [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occupancy;
    logic [2:0]        occupancy_limit;

    assign target_pc       = redirect_pc & WORD_MASK;
    assign pop             = (count != 2'd0) && out_ready;
    assign push            = inflight;
    assign occupancy       = {1'b0, count} + {2'b00, inflight};
    assign occupancy_limit = 3'd2 + {2'b00, pop};

    // A request is only issued when its response is guaranteed a FIFO slot.
    // Gating with reset keeps the strobe low while reset is held.
    always_comb begin
        issue = 1'b0;
        if (reset && !redirect_valid && (occupancy < occupancy_limit)) begin
            issue = 1'b1;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc[ADDR_W-1:2];
    assign out_valid = (count != 2'd0);
    assign out_pc    = fifo_pc[rd_ptr];
    assign out_instr = fifo_instr[rd_ptr];

    // Fetch PC and in-flight tracking; a redirect drops whatever is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= START_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= target_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + PC_STEP;
                inflight_pc <= pc;
            end
        end
    end

    // Two-entry response buffer; the push slot never aliases the head while it is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= inflight_pc;
                fifo_instr[wr_ptr] <= imem_rdata;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Decode back-pressure cycles, saturating instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of the PC.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port redirect_valid  input  1  branch or jump redirect request.
REQ-006 SHALL have port redirect_pc  input  ADDR_W  redirect target byte address.
REQ-007 SHALL have port imem_req  output  1  instruction-memory read strobe.
REQ-008 SHALL have port imem_addr  output  ADDR_W-2  word index, equal to pc[ADDR_W-1:2].
REQ-009 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-010 SHALL have port out_valid  output  1  fetched instruction available to decode.
REQ-011 SHALL have port out_ready  input  1  decode accepts the instruction.
REQ-012 SHALL have port out_pc  output  ADDR_W  byte address of the instruction in out_instr.
REQ-013 SHALL have port out_instr  output  32  instruction word.

Function
REQ-014 SHALL hold a fetch PC register; each issued request SHALL advance it by 4, modulo 2^ADDR_W (the value at 2^ADDR_W-4 wraps to 0).
REQ-015 SHALL buffer responses in a 2-entry FIFO that stores both PC and instruction.
REQ-016 SHALL assert imem_req only when FIFO count + in-flight (0 or 1) - pop_this_cycle < 2, so the FIFO never overflows.
REQ-017 SHALL register the PC of the in-flight request and push {pc, imem_rdata} into the FIFO on the cycle after that request.
REQ-018 SHALL drive out_valid = (count != 0), with out_pc and out_instr taken from the FIFO head.
REQ-019 SHALL pop the head when out_valid and out_ready are both high; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-020 SHALL hold out_pc and out_instr stable while out_valid=1 and out_ready=0.
REQ-021 SHALL give redirect_valid the highest priority; when it is asserted the block SHALL:
  - load PC with redirect_pc, with bits [1:0] forced to 0;
  - flush the FIFO (count goes to 0);
  - discard the in-flight response on the next cycle;
  - deassert imem_req in that cycle.
REQ-022 SHALL deassert out_valid in the cycle after a redirect, and SHALL issue the first request to the target in that same cycle.
REQ-023 SHALL have a redirect-to-out_valid latency of 2 cycles; the latency from reset deassertion to the first out_valid SHALL also be 2 cycles.
REQ-024 SHALL apply only the last value when redirects occur on back-to-back cycles; no stale instruction SHALL ever reach out_valid.

Reset
REQ-025 SHALL, while reset=0, asynchronously set PC=RESET_PC, FIFO count=0, in-flight=0, imem_req=0, out_valid=0, out_pc=0, and out_instr=0.
REQ-026 SHALL drop any in-flight response when reset is asserted mid-operation; fetch SHALL resume at RESET_PC.

Configuration
REQ-027 SHALL, when macro IFETCH_PERF_CNT_EN is defined, add output port stall_cnt (32 bits):
  - counts cycles with out_valid=1 and out_ready=0;
  - saturates at 0xFFFFFFFF;
  - resets to 0.
REQ-028 SHALL, when IFETCH_PERF_CNT_EN is undefined, have neither the stall_cnt port nor the counter logic, and SHALL otherwise behave identically.

Verification
REQ-029 SHALL cover reset release with out_ready=1 and memory returning the word index as data -> out_pc sequence 0, 4, 8, ... one per cycle from cycle 2, with out_instr matching.
REQ-030 SHALL cover out_ready=0 for 5 cycles -> FIFO fills to 2, imem_req drops, out_pc holds 0, and no instruction is lost or duplicated after release.
REQ-031 SHALL cover a redirect to 0x100 while the FIFO is full and a request is in flight -> PC 0x100 appears 2 cycles later and no old PC is ever presented.
REQ-032 SHALL cover redirect_pc=0x103 -> out_pc=0x100.
REQ-033 SHALL cover PC 0x3F8 with ADDR_W=10 -> out_pc sequence 0x3F8, 0x3FC, 0x000.
REQ-034 SHALL cover asserting reset mid-stream with out_ready toggling -> all outputs 0 immediately, then the sequence restarts from RESET_PC; with IFETCH_PERF_CNT_EN defined, stall_cnt equals the number of stalled cycles.
